// File: rtl/mem_arbiter.sv
// mem_arbiter: single-port memory sequencer for IF fetch and MEM load/store, data first, with global stall
// Ports: if_* fetch request/result, dm_* load/store request/result, mem_* memory command/read data,
// stall freezes the pipeline until every request of the step is serviced, stall_cnt counts stall cycles.
module mem_arbiter #(
  parameter int AW  = 10,
  parameter int LAT = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [31:0]   if_rdata,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [3:0]    dm_be,
  input  logic [AW-1:0] dm_addr,
  input  logic [31:0]   dm_wdata,
  output logic [31:0]   dm_rdata,
  output logic          stall,
  output logic          mem_en,
  output logic          mem_we,
  output logic [3:0]    mem_be,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata,
  output logic [31:0]   stall_cnt
);
  localparam logic [0:0] IDLE     = 1'b0;
  localparam logic [0:0] RD_WAIT  = 1'b1;
  localparam logic [2:0] CNT_INIT = 3'(LAT - 1);
  logic [0:0]  state_q, state_d;
  logic        owner_q, owner_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        if_done_q, if_done_d, dm_done_q, dm_done_d;
  logic [31:0] if_rdata_q, if_rdata_d, dm_rdata_q, dm_rdata_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic        need_d, need_i, idle, iss_d, iss_i, rd_iss, rd_done;
  assign need_d  = dm_req & ~dm_done_q;
  assign need_i  = if_req & ~if_done_q;
  assign idle    = state_q == IDLE;
  assign iss_d   = ~rst & idle & need_d;
  assign iss_i   = ~rst & idle & ~need_d & need_i;
  assign rd_iss  = iss_i | (iss_d & ~dm_we);
  assign rd_done = ~idle & (cnt_q == 3'd0);
  assign stall   = ~rst & (~idle | need_d | need_i);
  assign mem_en    = iss_d | iss_i;
  assign mem_we    = iss_d & dm_we;
  assign mem_be    = iss_d ? dm_be : 4'hF;
  assign mem_addr  = iss_d ? dm_addr : if_addr;
  assign mem_wdata = dm_wdata;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign stall_cnt = stall_cnt_q;
  // A stall-free cycle is the pipeline advance: both done flags clear for the next step.
  always_comb begin
    state_d     = rd_iss ? RD_WAIT : rd_done ? IDLE : state_q;
    cnt_d       = rd_iss ? CNT_INIT : (~idle & ~rd_done) ? cnt_q - 3'd1 : cnt_q;
    owner_d     = rd_iss ? iss_d : owner_q;
    if_done_d   = stall & (if_done_q | (rd_done & ~owner_q));
    dm_done_d   = stall & (dm_done_q | (rd_done & owner_q) | (iss_d & dm_we));
    if_rdata_d  = (rd_done & ~owner_q) ? mem_rdata : if_rdata_q;
    dm_rdata_d  = (rd_done & owner_q) ? mem_rdata : dm_rdata_q;
    stall_cnt_d = stall_cnt_q + 32'(stall);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      owner_q     <= 1'b0;
      cnt_q       <= 3'd0;
      if_done_q   <= 1'b0;
      dm_done_q   <= 1'b0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      cnt_q       <= cnt_d;
      if_done_q   <= if_done_d;
      dm_done_q   <= dm_done_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized pipeline steps checked against a step-level model of the arbiter
module tb_mem_arbiter;
  localparam int AW = 10;
  localparam int LAT = 2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic          if_req = 1'b0, dm_req = 1'b0, dm_we = 1'b0;
  logic [3:0]    dm_be = 4'h0;
  logic [AW-1:0] if_addr = '0, dm_addr = '0;
  logic [31:0]   dm_wdata = '0;
  logic [31:0]   if_rdata, dm_rdata, stall_cnt, mem_wdata, mem_rdata;
  logic          stall, mem_en, mem_we;
  logic [3:0]    mem_be;
  logic [AW-1:0] mem_addr;
  int n_vec = 0, n_err = 0, cyc = 0;
  logic [1:0] xr = 2'b00;
  mem_arbiter #(.AW(AW), .LAT(LAT)) dut (
    .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_be(dm_be), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .stall(stall), .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .stall_cnt(stall_cnt)
  );
  // Fetch-only builds at LAT=1 and LAT=4; read data is the cycle number so capture timing is visible.
  for (genvar g = 0; g < 2; g++) begin : gx
    logic st, en, mwe;
    logic [3:0] mbe;
    logic [AW-1:0] ma;
    logic [31:0] rd, drd, mwd, sc;
    mem_arbiter #(.AW(AW), .LAT(g ? 4 : 1)) u (
      .clk(clk), .rst(rst), .if_req(xr[g]), .if_addr(10'h004), .if_rdata(rd),
      .dm_req(1'b0), .dm_we(1'b0), .dm_be(4'h0), .dm_addr('0), .dm_wdata('0),
      .dm_rdata(drd), .stall(st), .mem_en(en), .mem_we(mwe), .mem_be(mbe),
      .mem_addr(ma), .mem_wdata(mwd), .mem_rdata(32'(cyc)), .stall_cnt(sc)
    );
  end
  always @(posedge clk) cyc <= cyc + 1;
  function automatic logic [31:0] iv(int i);
    return i == 4 ? 32'h8C01_0004 : 32'(i + 1) * 32'h9E37_79B1 ^ 32'hA5A5_0F0F;
  endfunction
  // Memory device: 16 aliased words, reads appear LAT cycles after issue, garbage otherwise.
  logic [31:0] dev [16];
  logic [31:0] pipe [1:LAT];
  assign mem_rdata = pipe[LAT];
  always @(posedge clk) begin
    pipe[1] <= (mem_en & ~mem_we) ? dev[mem_addr[3:0]] : $urandom;
    for (int k = 2; k <= LAT; k++) pipe[k] <= pipe[k-1];
    if (rst) for (int i = 0; i < 16; i++) dev[i] = iv(i);
    else if (mem_en & mem_we)
      for (int b = 0; b < 4; b++) if (mem_be[b]) dev[mem_addr[3:0]][8*b +: 8] = mem_wdata[8*b +: 8];
  end
  logic [31:0] ref_m [16];
  logic [31:0] exp_if, exp_dm, exp_sc;
  task automatic model_reset;
    for (int i = 0; i < 16; i++) ref_m[i] = iv(i);
    exp_if = '0;
    exp_dm = '0;
    exp_sc = '0;
  endtask
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  // One pipeline step: requests held until stall drops, then the step's outcome is compared.
  task automatic step(input logic ir, dr, we, input logic [3:0] be,
                      input logic [AW-1:0] ia, da, input logic [31:0] wd);
    int n = 0, np = 0, es, c0 = -1, c1 = -1;
    logic [AW-1:0] a0, a1;
    logic we0, we1;
    logic [3:0] be0, be1;
    logic [31:0] wd0;
    if_req = ir; dm_req = dr; dm_we = we; dm_be = be;
    if_addr = ia; dm_addr = da; dm_wdata = wd;
    es = (dr ? (we ? 1 : LAT + 1) : 0) + (ir ? LAT + 1 : 0);
    if (dr & we) begin
      for (int b = 0; b < 4; b++) if (be[b]) ref_m[da[3:0]][8*b +: 8] = wd[8*b +: 8];
    end else if (dr) exp_dm = ref_m[da[3:0]];
    if (ir) exp_if = ref_m[ia[3:0]];
    exp_sc += 32'(es);
    while (n <= 40) begin
      @(negedge clk);
      if (mem_en) begin
        if (np == 0) begin a0 = mem_addr; we0 = mem_we; be0 = mem_be; wd0 = mem_wdata; c0 = n; end
        else begin a1 = mem_addr; we1 = mem_we; be1 = mem_be; c1 = n; end
        np++;
      end
      if (!stall) break;
      n++;
    end
    chk("stall_len", n, es);
    chk("pulses", np, 32'(dr) + 32'(ir));
    if (dr | ir) begin
      chk("issue0_cyc", c0, 0);
      chk("addr0", a0, dr ? da : ia);
      chk("we0", we0, dr & we);
      chk("be0", be0, dr ? be : 4'hF);
      if (dr & we) chk("wdata0", wd0, wd);
    end
    if (dr & ir) begin
      chk("issue1_cyc", c1, we ? 1 : LAT + 1);
      chk("addr1", a1, ia);
      chk("we1", we1, 1'b0);
      chk("be1", be1, 4'hF);
    end
    chk("if_rdata", if_rdata, exp_if);
    chk("dm_rdata", dm_rdata, exp_dm);
    chk("stall_cnt", stall_cnt, exp_sc);
    @(posedge clk); #1;
  endtask
  task automatic lat_test;
    int n0 = 0, n1 = 0, i0 = -1, i1 = -1;
    bit f0 = 0, f1 = 0;
    logic [31:0] r0, r1;
    xr = 2'b11;
    for (int c = 0; c < 30 && !(f0 && f1); c++) begin
      @(negedge clk);
      if (!f0) begin
        if (gx[0].en) i0 = cyc;
        if (gx[0].st) n0++; else begin f0 = 1; r0 = gx[0].rd; xr[0] = 1'b0; end
      end
      if (!f1) begin
        if (gx[1].en) i1 = cyc;
        if (gx[1].st) n1++; else begin f1 = 1; r1 = gx[1].rd; xr[1] = 1'b0; end
      end
    end
    chk("lat1_stall", n0, 2);
    chk("lat4_stall", n1, 5);
    chk("lat1_data", r0, 32'(i0 + 1));
    chk("lat4_data", r1, 32'(i1 + 4));
    xr = 2'b00;
    @(posedge clk); #1;
  endtask
  initial begin
    model_reset();
    if_req = 1'b1; if_addr = 10'h004;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_stall", stall, 1'b0);
    chk("rst_mem_en", mem_en, 1'b0);
    chk("rst_if_rdata", if_rdata, 32'h0);
    chk("rst_stall_cnt", stall_cnt, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    step(1, 0, 0, 4'h0, 10'h004, 10'h000, 32'h0);
    chk("tp1_if", if_rdata, 32'h8C01_0004);
    chk("tp1_cnt", stall_cnt, 32'd3);
    step(1, 1, 1, 4'b0011, 10'h008, 10'h010, 32'hDEAD_BEEF);
    step(1, 1, 0, 4'hF, 10'h008, 10'h020, 32'h0);
    step(0, 0, 0, 4'h0, 10'h008, 10'h020, 32'h0);
    for (int s = 0; s < 3; s++) step(1, 0, 0, 4'h0, 10'(s * 4), 10'h0, 32'h0);
    for (int s = 0; s < 150; s++)
      step($urandom_range(0, 3) != 0, $urandom_range(0, 1), $urandom_range(0, 1),
           4'($urandom), 10'($urandom), 10'($urandom), $urandom);
    if_req = 1'b1; dm_req = 1'b0; if_addr = 10'h006;
    @(negedge clk);
    chk("mid_issue", mem_en, 1'b1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_stall", stall, 1'b0);
    chk("mid_rst_en", mem_en, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0; if_req = 1'b0;
    model_reset();
    @(negedge clk);
    chk("post_rst_stall", stall, 1'b0);
    chk("post_rst_if", if_rdata, 32'h0);
    chk("post_rst_cnt", stall_cnt, 32'h0);
    @(negedge clk);
    chk("post_rst_if2", if_rdata, 32'h0);
    @(posedge clk); #1;
    step(1, 0, 0, 4'h0, 10'h006, 10'h0, 32'h0);
    step(1, 1, 0, 4'h5, 10'h007, 10'h003, 32'h0);
    step(0, 0, 0, 4'h0, 10'h0, 10'h0, 32'h0);
    lat_test();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
